// File: rtl/decoder_scan_pkg.sv
// decoder_scan_pkg: shared types and helpers for the decoder_scan block.
//   state_e    : controller states (IDLE, DIRECT, SCAN)
//   onehot()   : index -> one-hot vector, sized for the widest supported select
//   Z_INACTIVE : per-bit idle level of z. It is set by DECODER_SCAN_ACTIVE_LOW_EN.
//                When the macro is defined, z is active-low and idles at all-ones.
//                When it is undefined, z is active-high and idles at all-zeros.
package decoder_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    // onehot() is written for the widest select the block supports.
    // Users cast its result down to OUT_N bits.
    localparam int ONEHOT_MAX_SEL_W = 8;
    localparam int ONEHOT_MAX_N     = 2 ** ONEHOT_MAX_SEL_W;

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    localparam logic Z_INACTIVE = 1'b1;
`else
    localparam logic Z_INACTIVE = 1'b0;
`endif

    function automatic logic [ONEHOT_MAX_N-1:0] onehot(input logic [ONEHOT_MAX_SEL_W-1:0] idx);
        logic [ONEHOT_MAX_N-1:0] vec;
        vec      = {ONEHOT_MAX_N{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/decoder_scan_onehot.sv
// decoder_scan_onehot: purely combinational SEL_W -> 2**SEL_W one-hot decode.
// It has no enable and always produces active-high output.
//   sel : index to decode
//   dec : one-hot result, dec[sel] = 1
// SEL_W must not exceed decoder_scan_pkg::ONEHOT_MAX_SEL_W.
module decoder_scan_onehot
    import decoder_scan_pkg::*;
#(
    parameter  int SEL_W = 3,
    localparam int OUT_N = 2 ** SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_N-1:0] dec
);

    assign dec = OUT_N'(onehot(ONEHOT_MAX_SEL_W'(sel)));

endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered N-to-2**N one-hot decoder with an auto-scan mode.
// Build option: DECODER_SCAN_ACTIVE_LOW_EN makes z active-low, with all-ones as the idle value.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset; it dominates every other input
//   enable : 0 blanks z and holds idx and the dwell counter
//   mode   : 0 = direct decode of sel, 1 = auto-scan
//   sel    : direct index, and the scan start index on scan entry
//   dwell  : cycles per scan step minus one
//   z      : registered one-hot select
//   idx    : current index register
//   wrap   : one-cycle pulse in the cycle after idx steps from OUT_N-1 to 0
module decoder_scan
    import decoder_scan_pkg::*;
#(
    parameter  int SEL_W   = 3,
    parameter  int DWELL_W = 8,
    localparam int OUT_N   = 2 ** SEL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_N-1:0]   z,
    output logic [SEL_W-1:0]   idx,
    output logic               wrap
);

    state_e             state_r;
    state_e             state_s;
    logic [DWELL_W-1:0] cnt_r;
    logic [DWELL_W-1:0] cnt_s;
    logic [SEL_W-1:0]   idx_s;
    logic               wrap_s;
    logic [OUT_N-1:0]   dec_s;
    logic [OUT_N-1:0]   z_s;

    // The decoder looks at the next index, so z is registered together with idx.
    decoder_scan_onehot #(
        .SEL_W (SEL_W)
    ) u_onehot (
        .sel (idx_s),
        .dec (dec_s)
    );

    // Next-state, next index and dwell counter, and the wrap pulse.
    always_comb begin
        state_s = state_r;
        idx_s   = idx;
        cnt_s   = cnt_r;
        wrap_s  = 1'b0;
        if (!enable) begin
            state_s = IDLE;
        end else if (!mode) begin
            state_s = DIRECT;
            idx_s   = sel;
            cnt_s   = {DWELL_W{1'b0}};
        end else begin
            state_s = SCAN;
            case (state_r)
                SCAN: begin
                    // >= instead of == so that lowering dwell below cnt still steps on the next edge.
                    if (cnt_r >= dwell) begin
                        cnt_s  = {DWELL_W{1'b0}};
                        idx_s  = idx + SEL_W'(1'b1);
                        wrap_s = (idx == {SEL_W{1'b1}});
                    end else begin
                        cnt_s  = cnt_r + DWELL_W'(1'b1);
                    end
                end
                IDLE, DIRECT: begin
                    // Scan entry: restart from sel and do not resume the earlier position.
                    idx_s = sel;
                    cnt_s = {DWELL_W{1'b0}};
                end
                default: begin
                    idx_s = sel;
                    cnt_s = {DWELL_W{1'b0}};
                end
            endcase
        end
    end

    // Apply output polarity and blank z while the block is disabled.
    always_comb begin
        z_s = {OUT_N{Z_INACTIVE}};
        if (enable) begin
            z_s = dec_s ^ {OUT_N{Z_INACTIVE}};
        end else begin
            z_s = {OUT_N{Z_INACTIVE}};
        end
    end

    // State and output registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            idx     <= {SEL_W{1'b0}};
            cnt_r   <= {DWELL_W{1'b0}};
            wrap    <= 1'b0;
            z       <= {OUT_N{Z_INACTIVE}};
        end else begin
            state_r <= state_s;
            idx     <= idx_s;
            cnt_r   <= cnt_s;
            wrap    <= wrap_s;
            z       <= z_s;
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed and randomized self-checking bench for decoder_scan (SEL_W=3, DWELL_W=8).
module tb_decoder_scan;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       mode;
    logic [2:0] sel;
    logic [7:0] dwell;
    logic [7:0] z;
    logic [2:0] idx;
    logic       wrap;

    int checks = 0;
    int errors = 0;

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    localparam logic [7:0] ZINV = 8'hFF;
`else
    localparam logic [7:0] ZINV = 8'h00;
`endif

    // Reference model state.
    int         m_idx   = 0;
    int         m_cnt   = 0;
    bit         m_scan  = 1'b0;
    logic [7:0] m_z     = 8'h00;
    logic       m_wrap  = 1'b0;

    decoder_scan #(
        .SEL_W   (3),
        .DWELL_W (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .mode   (mode),
        .sel    (sel),
        .dwell  (dwell),
        .z      (z),
        .idx    (idx),
        .wrap   (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge, using the inputs applied at that edge.
    task automatic model_step();
        if (reset) begin
            m_idx  = 0;
            m_cnt  = 0;
            m_wrap = 1'b0;
            m_scan = 1'b0;
            m_z    = ZINV;
        end else if (!enable) begin
            m_wrap = 1'b0;
            m_scan = 1'b0;
            m_z    = ZINV;
        end else begin
            m_wrap = 1'b0;
            if (!mode) begin
                m_idx  = int'(sel);
                m_cnt  = 0;
                m_scan = 1'b0;
            end else if (!m_scan) begin
                m_idx  = int'(sel);
                m_cnt  = 0;
                m_scan = 1'b1;
            end else if (m_cnt >= int'(dwell)) begin
                m_cnt  = 0;
                m_wrap = (m_idx == 7);
                m_idx  = (m_idx + 1) % 8;
            end else begin
                m_cnt  = m_cnt + 1;
            end
            m_z = ZINV ^ (8'h01 << m_idx);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_z", 32'(z), 32'(m_z));
        chk("model_idx", 32'(idx), 32'(m_idx));
        chk("model_wrap", 32'(wrap), 32'(m_wrap));
    endtask

    initial begin
        int exp_seq[10] = '{6, 6, 6, 7, 7, 7, 0, 0, 0, 1};

        reset  = 1'b1;
        enable = 1'b1;
        mode   = 1'b1;
        sel    = 3'd3;
        dwell  = 8'd0;

        // Reset dominates an enabled scan request.
        tick();
        tick();
        chk("rst_z", 32'(z), 32'(ZINV));
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);

        // Direct decode.
        reset = 1'b0;
        mode  = 1'b0;
        sel   = 3'd5;
        tick();
        chk("dir5_z", 32'(z), 32'(8'h20 ^ ZINV));
        chk("dir5_idx", 32'(idx), 32'd5);
        sel = 3'd0;
        tick();
        chk("dir0_z", 32'(z), 32'(8'h01 ^ ZINV));

        // Scan from 6 with dwell 2, across the 7 -> 0 wrap.
        mode  = 1'b1;
        sel   = 3'd6;
        dwell = 8'd2;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("seq_idx", 32'(idx), 32'(exp_seq[i]));
            chk("seq_wrap", 32'(wrap), (i == 6) ? 32'd1 : 32'd0);
        end

        // Disable blanks z, and re-enable restarts the scan from sel.
        dwell = 8'd0;
        sel   = 3'd3;
        tick();
        tick();
        tick();
        enable = 1'b0;
        sel    = 3'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dis_z", 32'(z), 32'(ZINV));
        end
        enable = 1'b1;
        tick();
        chk("reen_idx", 32'(idx), 32'd2);
        chk("reen_z", 32'(z), 32'(8'h04 ^ ZINV));

        // Lowering dwell below cnt forces a step on the next edge.
        mode = 1'b0;
        tick();
        mode  = 1'b1;
        dwell = 8'd10;
        sel   = 3'd1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("pre_low_idx", 32'(idx), 32'd1);
        dwell = 8'd1;
        tick();
        chk("low_step_idx", 32'(idx), 32'd2);
        tick();
        chk("low_hold_idx", 32'(idx), 32'd2);
        tick();
        chk("low_next_idx", 32'(idx), 32'd3);

        // Reset in the middle of a scan.
        dwell = 8'd3;
        sel   = 3'd4;
        mode  = 1'b0;
        tick();
        mode = 1'b1;
        tick();
        tick();
        chk("mid_idx", 32'(idx), 32'd4);
        reset = 1'b1;
        tick();
        chk("midrst_idx", 32'(idx), 32'd0);
        chk("midrst_z", 32'(z), 32'(ZINV));
        chk("midrst_wrap", 32'(wrap), 32'd0);
        reset = 1'b0;
        sel   = 3'd7;
        tick();
        chk("post_rst_idx", 32'(idx), 32'd7);

        // Randomized traffic checked against the model.
        for (int i = 0; i < 600; i++) begin
            reset  = ($urandom_range(0, 99) < 2);
            enable = ($urandom_range(0, 99) < 88);
            if ($urandom_range(0, 99) < 6) mode = ~mode;
            if ($urandom_range(0, 99) < 10) dwell = 8'($urandom_range(0, 4));
            sel = 3'($urandom_range(0, 7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
